// File: rtl/input_cmd_scheduler.sv
// input_cmd_scheduler: turns button levels into prioritized, coalesced game commands with DAS/ARR auto-repeat
module input_cmd_scheduler #(
    parameter int DAS_CYCLES = 20000000,
    parameter int ARR_CYCLES = 5000000,
    parameter int CW         = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_rot,
    input  logic       btn_drop,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    input  logic       cmd_ready
);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    state_t        st [3];
    state_t        st_nx [3];
    logic [CW-1:0] cnt [3];
    logic [CW-1:0] cnt_nx [3];
    logic [2:0]    rpt;
    logic [4:0]    btn, btn_q, press, ev, pend, acc, cand;
    logic [2:0]    nx_code;
    logic          conflict;
    assign btn      = {btn_drop, btn_rot, btn_down, btn_right, btn_left};
    assign press    = btn & ~btn_q;
    assign conflict = btn_left & btn_right;
    assign ev       = enable ? {press[4:3], press[2:0] | rpt} : '0;
    // pending bit index is cmd_code-1, so the accepted command maps to a one-hot mask
    assign acc      = (cmd_valid && cmd_ready) ? 5'b1 << (cmd_code - 3'd1) : '0;
    assign cand     = pend & ~acc;
    assign nx_code  = cand[4] ? 3'd5 : cand[3] ? 3'd4 : cand[0] ? 3'd1 :
                      cand[1] ? 3'd2 : cand[2] ? 3'd3 : 3'd0;
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            st_nx[i]  = st[i];
            cnt_nx[i] = cnt[i];
            rpt[i]    = 1'b0;
            if (!enable || !btn[i] || (i < 2 && conflict)) begin
                st_nx[i]  = IDLE;
                cnt_nx[i] = '0;
            end else begin
                case (st[i])
                    IDLE: begin
                        st_nx[i]  = press[i] ? DELAY : IDLE;
                        cnt_nx[i] = '0;
                    end
                    DELAY: begin
                        rpt[i]    = cnt[i] == CW'(DAS_CYCLES - 1);
                        st_nx[i]  = rpt[i] ? REPEAT : DELAY;
                        cnt_nx[i] = rpt[i] ? '0 : cnt[i] + 1'b1;
                    end
                    REPEAT: begin
                        rpt[i]    = cnt[i] == CW'(ARR_CYCLES - 1);
                        cnt_nx[i] = rpt[i] ? '0 : cnt[i] + 1'b1;
                    end
                    default: begin
                        st_nx[i]  = IDLE;
                        cnt_nx[i] = '0;
                    end
                endcase
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                st[i]  <= IDLE;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                st[i]  <= st_nx[i];
                cnt[i] <= cnt_nx[i];
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q     <= '0;
            pend      <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= 3'd0;
        end else begin
            btn_q <= btn;
            if (!enable) begin
                pend      <= '0;
                cmd_valid <= 1'b0;
                cmd_code  <= 3'd0;
            end else begin
                pend <= ev | cand;
                if (!cmd_valid || cmd_ready) begin
                    cmd_valid <= |cand;
                    cmd_code  <= nx_code;
                end
            end
        end
    end
endmodule

// File: tb/tb_input_cmd_scheduler.sv
// tb_input_cmd_scheduler: table-driven vectors plus directed multi-cycle sequences
module tb_input_cmd_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_rot = 1'b0, btn_drop = 1'b0;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_ready = 1'b0;
    int         checks = 0;
    int         passed = 0;
    int         cyc = 0;
    logic [2:0] acc_codes[$];
    int         acc_cyc[$];

    input_cmd_scheduler #(.DAS_CYCLES(8), .ARR_CYCLES(3), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
        .btn_rot(btn_rot), .btn_drop(btn_drop),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            acc_codes.push_back(cmd_code);
            acc_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    typedef struct packed {
        logic [4:0] btn;
        logic       ready;
        logic       en;
        logic       valid;
        logic [2:0] code;
    } vec_t;
    vec_t vecs [26];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input logic [4:0] b);
        {btn_drop, btn_rot, btn_down, btn_right, btn_left} = b;
    endtask

    task automatic clear_log();
        acc_codes.delete();
        acc_cyc.delete();
    endtask

    task automatic check_log(input string name, input int n, input logic [2:0] c0, input logic [2:0] c1);
        check({name, "_count"}, acc_codes.size(), n);
        if (acc_codes.size() > 0 && n > 0) check({name, "_code0"}, int'(acc_codes[0]), int'(c0));
        if (acc_codes.size() > 1 && n > 1) check({name, "_code1"}, int'(acc_codes[1]), int'(c1));
    endtask

    initial begin
        int cyc0;
        int exp_off [6];
        int stable;
        // btn order: {drop, rot, down, right, left}
        vecs[0]  = {5'b00000, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[1]  = {5'b01000, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[2]  = {5'b00000, 1'b1, 1'b1, 1'b1, 3'd4};
        vecs[3]  = {5'b00000, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[4]  = {5'b00000, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[5]  = {5'b11001, 1'b0, 1'b1, 1'b0, 3'd0};
        vecs[6]  = {5'b11001, 1'b0, 1'b1, 1'b1, 3'd5};
        vecs[7]  = {5'b00000, 1'b0, 1'b1, 1'b1, 3'd5};
        vecs[8]  = {5'b00000, 1'b0, 1'b1, 1'b1, 3'd5};
        vecs[9]  = {5'b00000, 1'b1, 1'b1, 1'b1, 3'd4};
        vecs[10] = {5'b00000, 1'b1, 1'b1, 1'b1, 3'd1};
        vecs[11] = {5'b00000, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[12] = {5'b00100, 1'b0, 1'b1, 1'b0, 3'd0};
        vecs[13] = {5'b00100, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[14] = {5'b00100, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[15] = {5'b00100, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[16] = {5'b00000, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[17] = {5'b01000, 1'b0, 1'b1, 1'b0, 3'd0};
        vecs[18] = {5'b00000, 1'b0, 1'b1, 1'b1, 3'd4};
        vecs[19] = {5'b01000, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[20] = {5'b00000, 1'b1, 1'b1, 1'b1, 3'd4};
        vecs[21] = {5'b00000, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[22] = {5'b00110, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[23] = {5'b00000, 1'b1, 1'b1, 1'b1, 3'd2};
        vecs[24] = {5'b00000, 1'b1, 1'b1, 1'b1, 3'd3};
        vecs[25] = {5'b00000, 1'b1, 1'b1, 1'b0, 3'd0};
        exp_off = '{2, 10, 13, 16, 19, 22};

        step(3);
        check("reset_state", {cmd_valid, cmd_code}, 0);
        rst_n = 1'b1;
        step(2);

        for (int i = 0; i < 26; i++) begin
            set_btn(vecs[i].btn);
            cmd_ready = vecs[i].ready;
            enable = vecs[i].en;
            step();
            check($sformatf("vec%0d", i), {cmd_valid, cmd_code}, {vecs[i].valid, vecs[i].code});
        end

        // auto-repeat: press edge, +8, then every 3
        set_btn(5'b00000);
        cmd_ready = 1'b1;
        step(2);
        clear_log();
        cyc0 = cyc;
        btn_left = 1'b1;
        step(21);
        btn_left = 1'b0;
        step(8);
        check("repeat_count", acc_codes.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < acc_codes.size()) begin
                check($sformatf("repeat_cyc%0d", i), acc_cyc[i] - cyc0, exp_off[i]);
                check($sformatf("repeat_code%0d", i), int'(acc_codes[i]), 1);
            end
        end

        // coalesce: repeat events while stalled collapse to one beat
        clear_log();
        cmd_ready = 1'b0;
        btn_down = 1'b1;
        step();
        stable = 1;
        for (int i = 0; i < 11; i++) begin
            step();
            if (!(cmd_valid && cmd_code == 3'd3)) stable = 0;
        end
        check("coalesce_stable", stable, 1);
        btn_down = 1'b0;
        step();
        cmd_ready = 1'b1;
        step(6);
        check_log("coalesce", 1, 3'd3, 3'd0);

        // left+right conflict: one event each, no repeats
        clear_log();
        btn_left = 1'b1;
        btn_right = 1'b1;
        step(15);
        btn_left = 1'b0;
        btn_right = 1'b0;
        step(5);
        check_log("conflict", 2, 3'd1, 3'd2);

        // async reset mid-REPEAT with a stalled command, then held key after reset
        clear_log();
        cmd_ready = 1'b0;
        btn_left = 1'b1;
        step(12);
        check("pre_reset_valid", {cmd_valid, cmd_code}, {1'b1, 3'd1});
        #2 rst_n = 1'b0;
        #1 check("reset_async", {cmd_valid, cmd_code}, 0);
        btn_left = 1'b0;
        btn_rot = 1'b1;
        cmd_ready = 1'b1;
        step(2);
        check("reset_held", {cmd_valid, cmd_code}, 0);
        rst_n = 1'b1;
        step(10);
        btn_rot = 1'b0;
        step(3);
        check_log("post_reset", 1, 3'd4, 3'd0);

        // enable drop while a command is stalled
        clear_log();
        cmd_ready = 1'b0;
        btn_drop = 1'b1;
        step(2);
        check("pre_disable", {cmd_valid, cmd_code}, {1'b1, 3'd5});
        enable = 1'b0;
        step();
        check("disable_flush", {cmd_valid, cmd_code}, 0);
        enable = 1'b1;
        cmd_ready = 1'b1;
        step(4);
        btn_drop = 1'b0;
        step(3);
        check_log("post_enable", 0, 3'd0, 3'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
